// File: rtl/spi_slave_frm.sv
// spi_slave_frm: framed SPI slave front-end between system-clock-sampled SPI pins and the RAM controller.
// Define SPI_PARITY_EN to add an odd-parity bit to every received frame and every read reply.
module spi_slave_frm #(
  parameter int PAY_W = 8,
  parameter int DATA_W = 8,
  parameter int TX_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic [PAY_W+1:0] rx_data,
  output logic rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic tx_valid,
  output logic frame_err,
  output logic busy
);
  localparam int FRAME_W = PAY_W + 2;
`ifdef SPI_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int TW = DATA_W + PAR;
  localparam int BW = $clog2(FRAME_W + 2);
  localparam int WW = $clog2(TX_WAIT_MAX + 1);
  localparam logic [BW-1:0] RX_LAST = BW'(FRAME_W - 1 + PAR);
  localparam logic [BW-1:0] TX_LAST = BW'(TW - 1);
  localparam logic [WW-1:0] W_LAST = WW'(TX_WAIT_MAX - 1);

  typedef enum logic [2:0] {IDLE, CHK_CMD, RECV, READ_WAIT, SHIFT_OUT, DONE} state_t;
  state_t state, state_n;
  logic [FRAME_W-1:0] sh, sh_n, rx_data_n;
  logic [TW-1:0] tsh, tsh_n, tx_word;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic rd_pend, rd_pend_n, miso_n, rx_valid_n, frame_err_n;

`ifdef SPI_PARITY_EN
  assign tx_word = {tx_data, ~^tx_data};
`else
  assign tx_word = tx_data;
`endif
  assign busy = state != IDLE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sh <= '0;
      tsh <= '0;
      bcnt <= '0;
      wcnt <= '0;
      rd_pend <= 1'b0;
      MISO <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      sh <= sh_n;
      tsh <= tsh_n;
      bcnt <= bcnt_n;
      wcnt <= wcnt_n;
      rd_pend <= rd_pend_n;
      MISO <= miso_n;
      rx_data <= rx_data_n;
      rx_valid <= rx_valid_n;
      frame_err <= frame_err_n;
    end
  end

  always_comb begin
    state_n = state;
    sh_n = sh;
    tsh_n = tsh;
    bcnt_n = bcnt;
    wcnt_n = wcnt;
    rd_pend_n = rd_pend;
    rx_data_n = rx_data;
    miso_n = 1'b0;
    rx_valid_n = 1'b0;
    frame_err_n = 1'b0;
    if (SS_n) begin
      state_n = IDLE;
      bcnt_n = '0;
      wcnt_n = '0;
      frame_err_n = state != IDLE && state != DONE;
    end else begin
      case (state)
        IDLE: state_n = CHK_CMD;
        CHK_CMD: begin
          sh_n = {sh[FRAME_W-2:0], MOSI};
          bcnt_n = BW'(1);
          state_n = RECV;
        end
        RECV: begin
          // the parity bit is checked against the frame but never shifted into it
          if (PAR == 0 || bcnt != RX_LAST) sh_n = {sh[FRAME_W-2:0], MOSI};
          bcnt_n = bcnt + 1'b1;
          if (bcnt == RX_LAST) begin
            bcnt_n = '0;
            state_n = DONE;
            if (PAR == 0 || ^{sh, MOSI}) begin
              rx_data_n = sh_n;
              rx_valid_n = 1'b1;
              rd_pend_n = rd_pend | (sh_n[FRAME_W-1 -: 2] == 2'b10);
              state_n = sh_n[FRAME_W-1 -: 2] == 2'b11 ? READ_WAIT : DONE;
            end else frame_err_n = 1'b1;
          end
        end
        READ_WAIT: begin
          wcnt_n = wcnt + 1'b1;
          if (tx_valid) begin
            miso_n = tx_word[TW-1];
            tsh_n = tx_word << 1;
            wcnt_n = '0;
            bcnt_n = '0;
            state_n = SHIFT_OUT;
          end else if (wcnt == W_LAST) begin
            wcnt_n = '0;
            frame_err_n = 1'b1;
            state_n = DONE;
          end
        end
        SHIFT_OUT: begin
          miso_n = tsh[TW-1];
          tsh_n = tsh << 1;
          bcnt_n = bcnt + 1'b1;
          if (bcnt == TX_LAST) begin
            miso_n = 1'b0;
            bcnt_n = '0;
            rd_pend_n = 1'b0;
            state_n = DONE;
          end
        end
        default: state_n = state;
      endcase
    end
  end
endmodule
